// File: rtl/uart_prog_loader.sv
// UART program loader: receives an 8N1 byte stream (16-bit word count, then
// little-endian 32-bit words) and writes each word into instruction memory.
module uart_prog_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_WIDTH   = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  input  logic                  load_en,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, DONE, ERR} state_t;

  // Registered status flags {busy, done, err} for a given loader state.
  function automatic logic [2:0] flags(input state_t s);
    return {(s == LEN_LO) || (s == LEN_HI) || (s == DATA), s == DONE, s == ERR};
  endfunction

  logic             rx_meta;
  logic             rx_sync;
  rx_state_t        rx_state;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       rx_shift;
  logic             byte_valid;
  logic             frame_err;

  state_t           state;
  logic [7:0]       len_lo;
  logic [15:0]      word_cnt;
  logic [1:0]       byte_idx;
  logic [31:0]      word_buf;

  // NOTE: synchronizer flops reset to the idle line level (1) so that reset
  // release can never be mistaken for a start bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // Receiver: mid-bit sampling, runs regardless of loader state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_state   <= RX_IDLE;
      clk_cnt    <= '0;
      bit_idx    <= '0;
      rx_shift   <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout sequential logic so every
      // flop samples the pre-edge values, independent of statement order.
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (!rx_sync) begin
            rx_state <= RX_START;
            clk_cnt  <= '0;
          end
        end
        RX_START: begin
          if (clk_cnt == HALF_LAST) begin
            clk_cnt  <= '0;
            bit_idx  <= '0;
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt  <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            bit_idx  <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) rx_state <= RX_STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt  <= '0;
            rx_state <= RX_IDLE;
            if (rx_sync) byte_valid <= 1'b1;
            else         frame_err  <= 1'b1;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Loader FSM; busy/done/err are registered alongside every state change.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      {busy, done, err} <= 3'b000;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      len_lo     <= '0;
      word_cnt   <= '0;
      byte_idx   <= '0;
      word_buf   <= '0;
    end else begin
      imem_we <= 1'b0;
      if (imem_we) begin
        imem_addr <= imem_addr + 1'b1;
        word_cnt  <= word_cnt - 16'd1;
      end
      case (state)
        IDLE: begin
          if (load_en) begin
            state     <= LEN_LO;
            {busy, done, err} <= flags(LEN_LO);
            imem_addr <= '0;
            byte_idx  <= '0;
            word_buf  <= '0;
          end
        end
        LEN_LO, LEN_HI, DATA: begin
          if (!load_en) begin
            // Abort wins over a coincident byte; written words are kept.
            state    <= IDLE;
            {busy, done, err} <= flags(IDLE);
            byte_idx <= '0;
          end else if (frame_err) begin
            state    <= ERR;
            {busy, done, err} <= flags(ERR);
            byte_idx <= '0;
          end else if (state == LEN_LO) begin
            if (byte_valid) begin
              len_lo <= rx_shift;
              state  <= LEN_HI;
              {busy, done, err} <= flags(LEN_HI);
            end
          end else if (state == LEN_HI) begin
            if (byte_valid) begin
              word_cnt <= {rx_shift, len_lo};
              byte_idx <= '0;
              if ({rx_shift, len_lo} == 16'd0) begin
                state <= DONE;
                {busy, done, err} <= flags(DONE);
              end else if (32'({rx_shift, len_lo}) > (32'd1 << ADDR_WIDTH)) begin
                state <= ERR;
                {busy, done, err} <= flags(ERR);
              end else begin
                state <= DATA;
                {busy, done, err} <= flags(DATA);
              end
            end
          end else begin
            if (imem_we && word_cnt == 16'd1) begin
              state <= DONE;
              {busy, done, err} <= flags(DONE);
            end else if (byte_valid) begin
              byte_idx <= byte_idx + 1'b1;
              if (byte_idx == 2'd3) begin
                imem_we    <= 1'b1;
                imem_wdata <= {rx_shift, word_buf[23:0]};
              end else begin
                word_buf[{byte_idx, 3'b000} +: 8] <= rx_shift;
              end
            end
          end
        end
        DONE, ERR: begin
          if (!load_en) begin
            state <= IDLE;
            {busy, done, err} <= flags(IDLE);
          end
        end
        default: begin
          state <= IDLE;
          {busy, done, err} <= flags(IDLE);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader: expected writes go into a scoreboard
// queue that a negedge monitor drains; status flags are checked inline.
module tb_uart_prog_loader;

  localparam int CPB = 16;
  localparam int AW  = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx;
  logic          load_en;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          busy;
  logic          done;
  logic          err;

  int n_checks = 0;
  int n_errors = 0;
  logic [AW+31:0] exp_q[$];

  uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .load_en    (load_en),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every write strobe must match the next queued word.
  always @(negedge clk) begin
    if (rst === 1'b1 && imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                 imem_addr, imem_wdata);
      end else begin
        check("write", 64'({imem_addr, imem_wdata}), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_seq(input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3);
    send_byte(b0, 1'b1);
    send_byte(b1, 1'b1);
    send_byte(b2, 1'b1);
    send_byte(b3, 1'b1);
  endtask

  task automatic start_load();
    load_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic stop_load();
    load_en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    rx = 1'b1;
    load_en = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({imem_we, busy, done, err}), 64'h0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Two-word program.
    start_load();
    check("busy_len_lo", 64'(busy), 64'h1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    exp_q.push_back({14'd0, 32'h0000_0013});
    send_seq(8'h13, 8'h00, 8'h00, 8'h00);
    exp_q.push_back({14'd1, 32'h0050_00B3});
    send_seq(8'hB3, 8'h00, 8'h50, 8'h00);
    check("prog2_done", 64'({busy, done, err}), 64'b010);
    stop_load();
    check("prog2_idle", 64'({busy, done, err}), 64'b000);

    // Zero-length program.
    start_load();
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    check("zero_len_done", 64'({busy, done, err}), 64'b010);
    load_en = 1'b0;
    @(negedge clk);
    check("zero_len_release", 64'(done), 64'h0);

    // Framing error mid-word discards the partial word.
    start_load();
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b0);
    check("frame_err", 64'({busy, done, err}), 64'b001);
    load_en = 1'b0;
    @(negedge clk);
    check("err_release", 64'(err), 64'h0);

    // Length bounds: 0x4001 too large, 0x4000 accepted.
    start_load();
    send_byte(8'h01, 1'b1);
    send_byte(8'h40, 1'b1);
    check("len_too_big", 64'({busy, done, err}), 64'b001);
    stop_load();
    start_load();
    send_byte(8'h00, 1'b1);
    send_byte(8'h40, 1'b1);
    check("len_max_ok", 64'({busy, done, err}), 64'b100);
    stop_load();
    check("len_max_abort", 64'(busy), 64'h0);

    // Short low glitch is a false start; length bytes still line up.
    start_load();
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_busy", 64'({busy, done, err}), 64'b100);
    send_byte(8'h00, 1'b1);
    check("glitch_len_hi", 64'({busy, done, err}), 64'b100);
    send_byte(8'h00, 1'b1);
    check("glitch_done", 64'({busy, done, err}), 64'b010);
    stop_load();

    // Abort mid second word: only word 0 is written.
    start_load();
    send_byte(8'h03, 1'b1);
    send_byte(8'h00, 1'b1);
    exp_q.push_back({14'd0, 32'h0000_0013});
    send_seq(8'h13, 8'h00, 8'h00, 8'h00);
    send_byte(8'hAA, 1'b1);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    load_en = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'h0);
    repeat (12 * CPB) @(negedge clk);

    // Reset in the middle of a byte clears everything.
    load_en = 1'b1;
    repeat (2) @(negedge clk);
    check("pre_reset_busy", 64'(busy), 64'h1);
    rx = 1'b0;
    repeat (30) @(negedge clk);
    rst = 1'b0;
    rx = 1'b1;
    @(negedge clk);
    check("midbyte_reset_flags", 64'({imem_we, busy, done, err}), 64'h0);
    check("midbyte_reset_addr", 64'(imem_addr), 64'h0);
    check("midbyte_reset_wdata", 64'(imem_wdata), 64'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    check("post_reset_fresh", 64'({busy, done, err}), 64'b010);
    stop_load();

    // Bytes with load_en low are ignored.
    send_byte(8'h05, 1'b1);
    send_byte(8'h00, 1'b1);
    check("idle_ignore", 64'({busy, done, err}), 64'b000);

    repeat (10) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_prog_loader.md
UART_PROG_LOADER -- requirements
Module: uart_prog_loader

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clock cycles per UART bit (100 MHz / 115200).
REQ-002 SHALL have parameter ADDR_WIDTH, default 14, instruction-memory word-address width.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port rx  input  1  UART serial line, idle high, 8N1, asynchronous to clk.
REQ-006 SHALL have port load_en  input  1  level; high requests and holds load mode.
REQ-007 SHALL have port imem_we  output  1  one-cycle instruction-memory write strobe.
REQ-008 SHALL have port imem_addr  output  ADDR_WIDTH  word address for the write.
REQ-009 SHALL have port imem_wdata  output  32  instruction word for the write.
REQ-010 SHALL have port busy  output  1  high in LEN_LO, LEN_HI, DATA.
REQ-011 SHALL have port done  output  1  high in DONE.
REQ-012 SHALL have port err  output  1  high in ERR.

Function
REQ-013 rx SHALL pass through a 2-flop synchronizer before any use.
REQ-014 Receiver: in RX_IDLE, synchronized rx low SHALL start a count of CLKS_PER_BIT/2 cycles, then re-sample; rx high at that point SHALL be a false start, return to RX_IDLE, and produce no byte.
REQ-015 Receiver SHALL then sample 8 data bits LSB first, one per CLKS_PER_BIT cycles, then sample the stop bit after a further CLKS_PER_BIT cycles.
REQ-016 Stop bit 1 SHALL produce a one-cycle byte_valid with the byte; stop bit 0 SHALL produce a one-cycle frame_err and no byte_valid.
REQ-017 Receiver SHALL run at all times; byte_valid and frame_err outside LEN_LO/LEN_HI/DATA SHALL be ignored.
REQ-018 Loader FSM states: IDLE, LEN_LO, LEN_HI, DATA, DONE, ERR.
REQ-019 IDLE -> LEN_LO when load_en=1; imem_addr SHALL clear to 0 on this transition.
REQ-020 LEN_LO: byte becomes length N[7:0] -> LEN_HI; LEN_HI: byte becomes N[15:8].
REQ-021 After LEN_HI: N=0 -> DONE; N > 2^ADDR_WIDTH -> ERR; otherwise -> DATA.
REQ-022 DATA: bytes SHALL assemble little-endian (first byte = wdata[7:0]); the 4th byte SHALL assert imem_we for exactly the cycle after that byte_valid with imem_wdata stable.
REQ-023 imem_addr SHALL increment by 1 in the cycle after each imem_we; the word count SHALL decrement likewise; count reaching 0 -> DONE.
REQ-024 frame_err in LEN_LO, LEN_HI or DATA -> ERR; a partially assembled word SHALL be discarded and not written.
REQ-025 DONE and ERR SHALL hold until load_en=0, then -> IDLE.
REQ-026 load_en=0 in LEN_LO, LEN_HI or DATA SHALL abort to IDLE next cycle with no further imem_we; words already written remain.
REQ-027 imem_we SHALL never assert outside DATA or more than once per 4 received bytes.
REQ-028 byte_valid coinciding with load_en falling SHALL be dropped (abort has priority).

Reset
REQ-029 rst=0 at a clock edge SHALL, regardless of state, force loader to IDLE, receiver to RX_IDLE, synchronizer flops to 1, and imem_we, imem_addr, imem_wdata, busy, done, err, word count and byte assembly to 0.
REQ-030 Reset mid-frame or mid-word SHALL discard partial data; the first valid start bit after release SHALL begin a fresh byte.

Verification (CLKS_PER_BIT=16, ADDR_WIDTH=14)
REQ-031 load_en=1; send 02 00, 13 00 00 00, B3 00 50 00 -> imem_we twice: addr 0 data 0x00000013, addr 1 data 0x005000B3; then done=1, busy=0.
REQ-032 load_en=1; send 00 00 -> no imem_we, done=1 after the 2nd byte; load_en=0 -> done=0 next cycle.
REQ-033 load_en=1; send 01 00, 11 22 then byte 33 with stop bit 0 -> err=1, no imem_we; load_en=0 -> IDLE.
REQ-034 rx low pulse of 4 cycles in LEN_LO -> no byte accepted, state stays LEN_LO.
REQ-035 load_en=1; send 03 00 and one full word, drop load_en mid 2nd word -> exactly one imem_we (addr 0), busy=0 next cycle; rst=0 during a byte -> all outputs 0 next edge.
REQ-036 load_en=0; send 05 00 -> no state change, busy=0, no imem_we.
